system_qsys_nios2_qsys_ocimem_arbiter: RTL and testbench

Arbitrates the Nios II on-chip debug (OCI) RAM between two requesters: decoded JTAG debug-module accesses (sysclk-domain strobes) and the CPU monitor's Avalon-style port. It buffers one JTAG request and auto-increments the JTAG address pointer. It returns JTAG read data in the MonDReg register and sequences every RAM access through a four-state FSM. It sits between the debug module's sysclk decode logic and the single-port OCI RAM.

---
 rtl/system_qsys_nios2_qsys_ocimem_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_system_qsys_nios2_qsys_ocimem_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/system_qsys_nios2_qsys_ocimem_arbiter.sv
// OCI RAM arbiter: JTAG debug strobes vs CPU Avalon port.
// One-entry JTAG buffer, auto-increment pointer, 4-state access FSM.
//
// Ports:
//   clk, reset_n        clock, async active-low reset
//   jtag_*              decoded JTAG strobes, pointer, status, MonDReg
//   cpu_*               Avalon slave (waitrequest handshake)
//   ram_*               registered single-port RAM interface
module system_qsys_nios2_qsys_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              jtag_ld_addr,
  input  logic [ADDR_W-1:0] jtag_addr,
  input  logic              jtag_rd,
  input  logic              jtag_wr,
  input  logic [DATA_W-1:0] jtag_wdata,
  input  logic              jtag_clr_err,
  output logic [DATA_W-1:0] mon_dreg,
  output logic              jtag_rdata_valid,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  output logic [ADDR_W-1:0] jtag_ptr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_read,
  input  logic              cpu_write,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_waitrequest,
  output logic              ram_cs,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_CAPTURE,
    S_COMPLETE
  } state_e;

  state_e state_q, state_d;

  logic              jpend_q;
  logic              jwe_q;
  logic [ADDR_W-1:0] jaddr_q;
  logic [DATA_W-1:0] jwdata_q;
  logic              busy_q;
  logic              ovr_q;
  logic [ADDR_W-1:0] ptr_q;

  logic              cpend_q;
  logic              cwe_q;
  logic [ADDR_W-1:0] caddr_q;
  logic [DATA_W-1:0] cwdata_q;

  logic              win_jtag_q;
  logic              op_we_q;
  logic              last_jtag_q;
  logic              ram_cs_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_wdata_q;
  logic [DATA_W-1:0] mon_q;
  logic [DATA_W-1:0] crd_q;

  logic grant;
  logic gnt_jtag;
  logic in_done;
  logic done_j;
  logic done_c;
  logic j_req;
  logic j_take;
  logic j_any;
  logic ovr_set;

  assign j_req  = jtag_rd | jtag_wr;
  assign j_any  = j_req | jtag_ld_addr;
  assign j_take = j_req & ~busy_q;
  // rd+wr together is served as a write but still flagged
  assign ovr_set = (busy_q & j_any)
                 | (j_take & jtag_rd & jtag_wr);

  assign in_done = (state_q == S_COMPLETE);
  assign done_j  = in_done & win_jtag_q;
  assign done_c  = in_done & ~win_jtag_q;

  always_comb begin
    state_d  = state_q;
    grant    = 1'b0;
    gnt_jtag = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (jpend_q | cpend_q) begin
          grant    = 1'b1;
          // round-robin only matters on a tie
          gnt_jtag = jpend_q
                   & (~cpend_q | ~last_jtag_q);
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = op_we_q ? S_COMPLETE
                          : S_CAPTURE;
      end
      S_CAPTURE:  state_d = S_COMPLETE;
      S_COMPLETE: state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jpend_q  <= 1'b0;
      jwe_q    <= 1'b0;
      jaddr_q  <= '0;
      jwdata_q <= '0;
      busy_q   <= 1'b0;
      ovr_q    <= 1'b0;
      ptr_q    <= '0;
    end else begin
      if (ovr_set)           ovr_q <= 1'b1;
      else if (jtag_clr_err) ovr_q <= 1'b0;
      if (j_take) begin
        jpend_q  <= 1'b1;
        busy_q   <= 1'b1;
        jwe_q    <= jtag_wr;
        jaddr_q  <= jtag_ld_addr ? jtag_addr
                                 : ptr_q;
        jwdata_q <= jtag_wdata;
      end else begin
        if (grant & gnt_jtag) jpend_q <= 1'b0;
        if (done_j)           busy_q  <= 1'b0;
      end
      if (done_j)
        ptr_q <= ram_addr_q + ADDR_W'(1);
      else if (jtag_ld_addr & ~busy_q)
        ptr_q <= jtag_addr;
    end
  end

  // CPU request is captured only while idle and held until served
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cpend_q  <= 1'b0;
      cwe_q    <= 1'b0;
      caddr_q  <= '0;
      cwdata_q <= '0;
    end else if (state_q == S_IDLE && !cpend_q) begin
      cpend_q  <= cpu_read | cpu_write;
      cwe_q    <= cpu_write;
      caddr_q  <= cpu_addr;
      cwdata_q <= cpu_wdata;
    end else if (done_c) begin
      cpend_q  <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      win_jtag_q  <= 1'b0;
      op_we_q     <= 1'b0;
      last_jtag_q <= 1'b0;
      ram_cs_q    <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      ram_cs_q <= grant;
      ram_we_q <= grant
                & (gnt_jtag ? jwe_q : cwe_q);
      if (grant) begin
        win_jtag_q  <= gnt_jtag;
        op_we_q     <= gnt_jtag ? jwe_q : cwe_q;
        ram_addr_q  <= gnt_jtag ? jaddr_q
                                : caddr_q;
        ram_wdata_q <= gnt_jtag ? jwdata_q
                                : cwdata_q;
      end
      if (in_done) last_jtag_q <= win_jtag_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_q <= '0;
      crd_q <= '0;
    end else if (state_q == S_CAPTURE) begin
      if (win_jtag_q) mon_q <= ram_rdata;
      else            crd_q <= ram_rdata;
    end
  end

  assign mon_dreg         = mon_q;
  assign cpu_readdata     = crd_q;
  assign jtag_busy        = busy_q;
  assign jtag_overrun     = ovr_q;
  assign jtag_ptr         = ptr_q;
  assign jtag_rdata_valid = done_j & ~op_we_q;
  assign cpu_waitrequest  = ~done_c;
  assign ram_cs           = ram_cs_q;
  assign ram_we           = ram_we_q;
  assign ram_addr         = ram_addr_q;
  assign ram_wdata        = ram_wdata_q;

endmodule

// File: tb/tb_system_qsys_nios2_qsys_ocimem_arbiter.sv
// Bench for the OCI RAM arbiter.
// Transaction-timeline model, RAM model, directed + random stimulus.
module tb_system_qsys_nios2_qsys_ocimem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        jtag_ld_addr = 1'b0;
  logic [7:0]  jtag_addr = '0;
  logic        jtag_rd = 1'b0;
  logic        jtag_wr = 1'b0;
  logic [31:0] jtag_wdata = '0;
  logic        jtag_clr_err = 1'b0;
  logic [31:0] mon_dreg;
  logic        jtag_rdata_valid;
  logic        jtag_busy;
  logic        jtag_overrun;
  logic [7:0]  jtag_ptr;
  logic [7:0]  cpu_addr = '0;
  logic        cpu_read = 1'b0;
  logic        cpu_write = 1'b0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_readdata;
  logic        cpu_waitrequest;
  logic        ram_cs;
  logic        ram_we;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  always #5 clk = ~clk;

  system_qsys_nios2_qsys_ocimem_arbiter #(
    .ADDR_W(8),
    .DATA_W(32)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .jtag_ld_addr(jtag_ld_addr),
    .jtag_addr(jtag_addr),
    .jtag_rd(jtag_rd),
    .jtag_wr(jtag_wr),
    .jtag_wdata(jtag_wdata),
    .jtag_clr_err(jtag_clr_err),
    .mon_dreg(mon_dreg),
    .jtag_rdata_valid(jtag_rdata_valid),
    .jtag_busy(jtag_busy),
    .jtag_overrun(jtag_overrun),
    .jtag_ptr(jtag_ptr),
    .cpu_addr(cpu_addr),
    .cpu_read(cpu_read),
    .cpu_write(cpu_write),
    .cpu_wdata(cpu_wdata),
    .cpu_readdata(cpu_readdata),
    .cpu_waitrequest(cpu_waitrequest),
    .ram_cs(ram_cs),
    .ram_we(ram_we),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // single-port RAM, one-cycle read latency
  logic [31:0] mem [256];
  logic        pk_en = 1'b0;
  logic [7:0]  pk_a = '0;
  logic [31:0] pk_d = '0;

  always @(posedge clk) begin
    if (pk_en) mem[pk_a] <= pk_d;
    if (ram_cs) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      else        ram_rdata <= mem[ram_addr];
    end
  end

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int cs_cnt = 0;
  int vld_cnt = 0;
  bit chk_en = 1'b0;
  bit cpu_fin = 1'b0;

  function automatic void chk(string nm,
                              logic [31:0] a,
                              logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h want %h cyc %0d",
               nm, a, e, cyc);
    end
  endfunction

  // model: one buffered request per side plus
  // the in-flight access described by grant cycle tg
  logic [31:0] mmem [256];
  bit          jp, jwe, cp, cwe, act, aj, awe;
  bit          last, ovr;
  logic [7:0]  ja, ca, aa, ptr;
  logic [31:0] jd, cd, ad, mon, crd;
  int          tg;

  function automatic logic [31:0] f(int i);
    return 32'hC0DE_0000 ^ (i * 32'h0001_0025);
  endfunction

  function automatic void model_reset();
    jp = 0; cp = 0; act = 0; last = 0; ovr = 0;
    ptr = '0; mon = '0; crd = '0;
    awe = 0; aj = 0; tg = -10;
  endfunction

  function automatic void model_edge();
    int  p, dn;
    bit  idle, busyp, cpo, rq, st, set;
    if (!reset_n) begin
      model_reset();
      return;
    end
    p = cyc;
    idle = !act;
    busyp = jp || (act && aj);
    cpo = cp;
    dn = tg + (awe ? 2 : 3);
    if (act && awe && p == tg + 1) mmem[aa] = ad;
    if (act && !awe && p == tg + 2) begin
      if (aj) mon = mmem[aa];
      else    crd = mmem[aa];
    end
    if (act && p == dn) begin
      if (aj) ptr = aa + 8'd1;
      last = aj;
      act = 0;
    end
    if (idle && (jp || cp)) begin
      aj = jp && (!cp || !last);
      if (aj) begin
        awe = jwe; aa = ja; ad = jd; jp = 0;
      end else begin
        awe = cwe; aa = ca; ad = cd; cp = 0;
      end
      act = 1;
      tg = p;
    end
    if (idle && !cpo) begin
      cp = cpu_read || cpu_write;
      cwe = cpu_write;
      ca = cpu_addr;
      cd = cpu_wdata;
    end
    rq = jtag_rd || jtag_wr;
    st = rq || jtag_ld_addr;
    set = (busyp && st)
       || (!busyp && jtag_rd && jtag_wr);
    if (set) ovr = 1;
    else if (jtag_clr_err) ovr = 0;
    if (!busyp) begin
      if (jtag_ld_addr) ptr = jtag_addr;
      if (rq) begin
        jp = 1; jwe = jtag_wr;
        ja = ptr; jd = jtag_wdata;
      end
    end
  endfunction

  int dn_c;
  bit ecs;

  always @(negedge clk) begin
    if (chk_en) begin
      dn_c = tg + (awe ? 2 : 3);
      ecs = act && cyc == tg + 1;
      chk("ram_cs", 32'(ram_cs), 32'(ecs));
      chk("ram_we", 32'(ram_we), 32'(ecs && awe));
      if (ecs) begin
        chk("ram_addr", 32'(ram_addr), 32'(aa));
        if (awe) chk("ram_wdata", ram_wdata, ad);
      end
      chk("waitreq", 32'(cpu_waitrequest),
          32'(!(act && !aj && cyc == dn_c)));
      chk("rvalid", 32'(jtag_rdata_valid),
          32'(act && aj && !awe && cyc == dn_c));
      chk("busy", 32'(jtag_busy),
          32'(jp || (act && aj)));
      chk("overrun", 32'(jtag_overrun), 32'(ovr));
      chk("ptr", 32'(jtag_ptr), 32'(ptr));
      chk("mon_dreg", mon_dreg, mon);
      chk("cpu_rdata", cpu_readdata, crd);
    end
    if (ram_cs) cs_cnt++;
    if (jtag_rdata_valid) vld_cnt++;
  end

  task automatic step();
    @(posedge clk);
    #1;
    model_edge();
    cyc++;
    jtag_rd = 0; jtag_wr = 0;
    jtag_ld_addr = 0; jtag_clr_err = 0;
    pk_en = 0;
    if (cpu_fin) begin
      cpu_read = 0;
      cpu_write = 0;
    end
    cpu_fin = (cpu_read || cpu_write)
           && !cpu_waitrequest;
  endtask

  task automatic poke(input logic [7:0] a,
                      input logic [31:0] d);
    pk_en = 1; pk_a = a; pk_d = d;
    mmem[a] = d;
    step();
  endtask

  task automatic wait_cs(input string nm,
                         input logic [7:0] ea);
    int n;
    n = 0;
    step();
    while (!ram_cs && n < 12) begin
      step();
      n++;
    end
    if (ram_cs) chk(nm, 32'(ram_addr), 32'(ea));
    else        chk({nm, " timeout"}, 0, 1);
  endtask

  int c0, v0;

  initial begin
    model_reset();
    for (int i = 0; i < 256; i++) poke(8'(i), f(i));
    step();
    chk("rst mon", mon_dreg, 0);
    chk("rst crd", cpu_readdata, 0);
    chk("rst ptr", 32'(jtag_ptr), 0);
    chk("rst raddr", 32'(ram_addr), 0);
    chk("rst rwdata", ram_wdata, 0);
    chk("rst cs", 32'(ram_cs), 0);
    chk("rst we", 32'(ram_we), 0);
    chk("rst wait", 32'(cpu_waitrequest), 1);
    chk("rst busy", 32'(jtag_busy), 0);
    chk("rst ovr", 32'(jtag_overrun), 0);
    chk("rst vld", 32'(jtag_rdata_valid), 0);
    chk_en = 1;
    reset_n = 1;
    repeat (2) step();

    // ld_addr + wr in one cycle
    c0 = cs_cnt;
    jtag_ld_addr = 1; jtag_addr = 8'h10;
    jtag_wr = 1; jtag_wdata = 32'hDEADBEEF;
    step();
    chk("t1 busy", 32'(jtag_busy), 1);
    step();
    chk("t1 cs", 32'(ram_cs), 1);
    chk("t1 we", 32'(ram_we), 1);
    chk("t1 addr", 32'(ram_addr), 32'h10);
    chk("t1 data", ram_wdata, 32'hDEADBEEF);
    repeat (2) step();
    chk("t1 idle", 32'(jtag_busy), 0);
    chk("t1 ptr", 32'(jtag_ptr), 32'h11);
    chk("t1 cs cnt", cs_cnt - c0, 1);

    // CPU read latency
    poke(8'h05, 32'h12345678);
    c0 = cs_cnt;
    cpu_read = 1; cpu_addr = 8'h05;
    for (int i = 1; i <= 3; i++) begin
      step();
      chk("t2 wait hi", 32'(cpu_waitrequest), 1);
    end
    step();
    chk("t2 wait lo", 32'(cpu_waitrequest), 0);
    chk("t2 rdata", cpu_readdata, 32'h12345678);
    step();
    chk("t2 cs cnt", cs_cnt - c0, 1);

    // ties
    jtag_wr = 1; jtag_wdata = 32'h11111111;
    cpu_write = 1; cpu_addr = 8'h20;
    cpu_wdata = 32'h22222222;
    repeat (2) step();
    chk("tie1 jtag first", 32'(ram_addr), 32'h11);
    wait_cs("tie1 cpu second", 8'h20);
    repeat (4) step();
    jtag_wr = 1; jtag_wdata = 32'h33333333;
    repeat (6) step();
    jtag_wr = 1; jtag_wdata = 32'h44444444;
    cpu_write = 1; cpu_addr = 8'h21;
    cpu_wdata = 32'h55555555;
    repeat (2) step();
    chk("tie2 cs", 32'(ram_cs), 1);
    chk("tie2 cpu first", 32'(ram_addr), 32'h21);
    wait_cs("tie2 jtag second", 8'h13);
    repeat (6) step();

    // pointer wrap on read
    poke(8'hFF, 32'hA5A5A5A5);
    jtag_ld_addr = 1; jtag_addr = 8'hFF;
    step();
    chk("t4 ptr ld", 32'(jtag_ptr), 32'hFF);
    v0 = vld_cnt;
    jtag_rd = 1;
    repeat (8) step();
    chk("t4 mon", mon_dreg, 32'hA5A5A5A5);
    chk("t4 vld cnt", vld_cnt - v0, 1);
    chk("t4 wrap", 32'(jtag_ptr), 0);

    // overrun
    c0 = cs_cnt;
    jtag_wr = 1; jtag_wdata = 32'hAAAA0001;
    step();
    jtag_wr = 1; jtag_wdata = 32'hBBBB0002;
    step();
    chk("t5 ovr", 32'(jtag_overrun), 1);
    repeat (8) step();
    chk("t5 cs cnt", cs_cnt - c0, 1);
    chk("t5 ovr hold", 32'(jtag_overrun), 1);
    chk("t5 ptr", 32'(jtag_ptr), 1);
    jtag_wr = 1; jtag_wdata = 32'hCCCC0003;
    step();
    jtag_rd = 1; jtag_clr_err = 1;
    step();
    chk("t5 set>clr", 32'(jtag_overrun), 1);
    repeat (8) step();
    jtag_clr_err = 1;
    step();
    chk("t5 clr", 32'(jtag_overrun), 0);

    // async reset during CPU read capture
    poke(8'h33, 32'h600DF00D);
    cpu_read = 1; cpu_addr = 8'h33;
    repeat (3) step();
    #1;
    reset_n = 0;
    model_reset();
    cpu_read = 0;
    #1;
    chk("t6 wait", 32'(cpu_waitrequest), 1);
    chk("t6 crd", cpu_readdata, 0);
    chk("t6 ptr", 32'(jtag_ptr), 0);
    chk("t6 cs", 32'(ram_cs), 0);
    repeat (2) step();
    reset_n = 1;
    step();
    cpu_read = 1; cpu_addr = 8'h33;
    repeat (4) step();
    chk("t6 wait lo", 32'(cpu_waitrequest), 0);
    chk("t6 rdata", cpu_readdata, 32'h600DF00D);
    repeat (2) step();

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      jtag_rd = ($urandom_range(0, 5) == 0);
      jtag_wr = ($urandom_range(0, 5) == 0);
      jtag_ld_addr = ($urandom_range(0, 7) == 0);
      jtag_addr = 8'($urandom);
      jtag_wdata = $urandom;
      jtag_clr_err = ($urandom_range(0, 9) == 0);
      if (!cpu_read && !cpu_write) begin
        if ($urandom_range(0, 2) == 0) begin
          cpu_write = $urandom_range(0, 1) == 1;
          cpu_read = !cpu_write;
          cpu_addr = 8'($urandom);
          cpu_wdata = $urandom;
        end
      end else if (!cpu_fin
                   && $urandom_range(0, 7) == 0) begin
        cpu_addr = 8'($urandom);
        cpu_wdata = $urandom;
      end
      step();
    end
    repeat (10) step();

    $display("[TB] %0d tests run, %0d failed",
             tests, fails);
    $finish;
  end

endmodule
